// File: rtl/stream_accum.sv
// stream_accum: groups an unsigned sample stream into sums of COUNT samples.
// A group closes when its COUNT-th sample is accepted or when flush is seen
// with at least one sample pending (the flush-cycle sample is included).
// Results appear one cycle after the closing edge with a single-cycle strobe.
// Optional macro STREAM_ACCUM_SAT_EN: saturate the sum at 2^SUM_WIDTH-1
// instead of wrapping. The overflow flag is reported either way.
module stream_accum #(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int SUM_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic                 flush,
  output logic                 dout_valid,
  output logic [SUM_WIDTH-1:0] dout,
  output logic [7:0]           dout_cnt,
  output logic                 dout_ovf
);

  localparam logic [7:0] COUNT_C = 8'(COUNT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SUM_WIDTH-1:0] r_acc;
  logic [SUM_WIDTH-1:0] w_acc_nxt;
  logic [SUM_WIDTH-1:0] w_sum;
  logic [SUM_WIDTH:0]   w_add;
  logic [7:0]           r_cnt;
  logic [7:0]           w_cnt_nxt;
  logic [7:0]           w_cnt_inc;
  logic                 r_ovf;
  logic                 w_ovf_nxt;
  logic                 w_carry;
  logic                 w_close;

  // Add the zero-extended sample to the running sum and derive the carry.
  always_comb begin
    w_add     = {1'b0, r_acc} + {{(SUM_WIDTH + 1 - WIDTH){1'b0}}, din};
    w_carry   = din_valid & w_add[SUM_WIDTH];
    w_cnt_inc = r_cnt + 8'd1;
`ifdef STREAM_ACCUM_SAT_EN
    // Once saturated the sum is all ones, so any further non-zero sample
    // carries again and the value stays pinned for the rest of the group.
    if (w_add[SUM_WIDTH]) begin
      w_sum = {SUM_WIDTH{1'b1}};
    end else begin
      w_sum = w_add[SUM_WIDTH-1:0];
    end
`else
    w_sum = w_add[SUM_WIDTH-1:0];
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, next-accumulator and group-close decision.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_close     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (din_valid) begin
          w_acc_nxt = w_sum;
          w_cnt_nxt = 8'd1;
          w_ovf_nxt = w_carry;
          if ((COUNT_C == 8'd1) || flush) begin
            w_close = 1'b1;
          end else begin
            w_state_nxt = S_ACC;
          end
        end else begin
          // A flush with nothing pending produces no group.
          w_state_nxt = S_IDLE;
        end
      end
      S_ACC: begin
        if (din_valid) begin
          w_acc_nxt = w_sum;
          w_cnt_nxt = w_cnt_inc;
          w_ovf_nxt = r_ovf | w_carry;
          if ((w_cnt_inc == COUNT_C) || flush) begin
            w_close = 1'b1;
          end else begin
            w_state_nxt = S_ACC;
          end
        end else if (flush) begin
          w_close = 1'b1;
        end else begin
          w_state_nxt = S_ACC;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_acc_nxt   = {SUM_WIDTH{1'b0}};
        w_cnt_nxt   = 8'd0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
    if (w_close) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Accumulator registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= {SUM_WIDTH{1'b0}};
      r_cnt      <= 8'd0;
      r_ovf      <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= {SUM_WIDTH{1'b0}};
      dout_cnt   <= 8'd0;
      dout_ovf   <= 1'b0;
    end else begin
      dout_valid <= w_close;
      if (w_close) begin
        dout     <= w_acc_nxt;
        dout_cnt <= w_cnt_nxt;
        dout_ovf <= w_ovf_nxt;
        r_acc    <= {SUM_WIDTH{1'b0}};
        r_cnt    <= 8'd0;
        r_ovf    <= 1'b0;
      end else begin
        r_acc    <= w_acc_nxt;
        r_cnt    <= w_cnt_nxt;
        r_ovf    <= w_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_stream_accum.sv
// Testbench for stream_accum. Two instances share one stimulus stream:
// A uses SUM_WIDTH=10, B uses SUM_WIDTH=9 (for overflow behaviour).
// The reference model keeps the pending samples in a queue and computes
// each group's result from the integer total.
module tb_stream_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'd0;
  logic       flush = 1'b0;

  logic       a_valid;
  logic [9:0] a_dout;
  logic [7:0] a_cnt;
  logic       a_ovf;
  logic       b_valid;
  logic [8:0] b_dout;
  logic [7:0] b_cnt;
  logic       b_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int   grp[$];
  logic e_valid = 1'b0;
  int   e_total = 0;
  int   e_cnt   = 0;
  int   e_a_dout = 0;
  logic e_a_ovf  = 1'b0;
  int   e_b_dout = 0;
  logic e_b_ovf  = 1'b0;

  stream_accum #(.WIDTH(8), .COUNT(4), .SUM_WIDTH(10)) u_a (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .flush(flush),
    .dout_valid(a_valid), .dout(a_dout), .dout_cnt(a_cnt), .dout_ovf(a_ovf)
  );

  stream_accum #(.WIDTH(8), .COUNT(4), .SUM_WIDTH(9)) u_b (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .flush(flush),
    .dout_valid(b_valid), .dout(b_dout), .dout_cnt(b_cnt), .dout_ovf(b_ovf)
  );

  always #5 clk = ~clk;

  function automatic int exp_dout(input int total, input int sw);
`ifdef STREAM_ACCUM_SAT_EN
    return (total >= (1 << sw)) ? ((1 << sw) - 1) : total;
`else
    return total % (1 << sw);
`endif
  endfunction

  // Drive one cycle of stimulus, then advance the model for that edge.
  task automatic step(input logic v, input logic [7:0] d, input logic f);
    int s;
    din_valid = v;
    din       = d;
    flush     = f;
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    if (v) grp.push_back(int'(d));
    if ((v && grp.size() == 4) || (f && grp.size() > 0)) begin
      s = 0;
      foreach (grp[i]) s += grp[i];
      e_valid  = 1'b1;
      e_total  = s;
      e_cnt    = grp.size();
      e_a_dout = exp_dout(s, 10);
      e_a_ovf  = (s >= 1024);
      e_b_dout = exp_dout(s, 9);
      e_b_ovf  = (s >= 512);
      grp.delete();
    end
    din_valid = 1'b0;
    din       = 8'd0;
    flush     = 1'b0;
  endtask

  task automatic clear_model();
    grp.delete();
    e_valid = 1'b0; e_total = 0; e_cnt = 0;
    e_a_dout = 0; e_a_ovf = 1'b0; e_b_dout = 0; e_b_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 2;
    if ({a_valid, a_dout, a_cnt, a_ovf} !== 20'd0) begin
      n_bad++; $display("FAIL reset_a got %0b/%0d/%0d/%0b want 0/0/0/0", a_valid, a_dout, a_cnt, a_ovf);
    end
    if ({b_valid, b_dout, b_cnt, b_ovf} !== 19'd0) begin
      n_bad++; $display("FAIL reset_b got %0b/%0d/%0d/%0b want 0/0/0/0", b_valid, b_dout, b_cnt, b_ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int smp[5] = '{10, 20, 30, 40, 0};
    for (int i = 0; i < 5; i++) begin
      step(i < 4, 8'(smp[i]), 1'b0);
      n_cmp += 2;
      if (a_valid !== e_valid) begin
        n_bad++; $display("FAIL basic_valid[%0d] got %0b want %0b", i, a_valid, e_valid);
      end
      if ({a_dout, a_cnt, a_ovf} !== {10'(e_a_dout), 8'(e_cnt), e_a_ovf}) begin
        n_bad++; $display("FAIL basic_out[%0d] got %0d/%0d/%0b want %0d/%0d/%0b", i, a_dout, a_cnt, a_ovf, e_a_dout, e_cnt, e_a_ovf);
      end
    end
    // Hand-derived check of the final result, independent of the model.
    n_cmp += 1;
    if ({a_dout, a_cnt, a_ovf} !== {10'd100, 8'd4, 1'b0}) begin
      n_bad++; $display("FAIL basic_fixed got %0d/%0d/%0b want 100/4/0", a_dout, a_cnt, a_ovf);
    end
  endtask

  task automatic test_gaps_back_to_back();
    int strobes = 0;
    for (int k = 1; k <= 8; k++) begin
      int gaps = (k == 5) ? 0 : int'($urandom_range(0, 2));
      for (int g = 0; g <= gaps; g++) begin
        if (g == gaps) step(1'b1, 8'(k), 1'b0);
        else           step(1'b0, 8'($urandom), 1'b0);
        n_cmp += 2;
        if (a_valid !== e_valid) begin
          n_bad++; $display("FAIL gaps_valid k=%0d got %0b want %0b", k, a_valid, e_valid);
        end
        if ({a_dout, a_cnt, a_ovf} !== {10'(e_a_dout), 8'(e_cnt), e_a_ovf}) begin
          n_bad++; $display("FAIL gaps_out k=%0d got %0d/%0d/%0b want %0d/%0d/%0b", k, a_dout, a_cnt, a_ovf, e_a_dout, e_cnt, e_a_ovf);
        end
        if (a_valid === 1'b1) strobes++;
      end
      if (k == 4) begin
        n_cmp += 1;
        if ({a_valid, a_dout, a_cnt} !== {1'b1, 10'd10, 8'd4}) begin
          n_bad++; $display("FAIL gaps_first got %0b/%0d/%0d want 1/10/4", a_valid, a_dout, a_cnt);
        end
      end
    end
    n_cmp += 2;
    if ({a_valid, a_dout, a_cnt} !== {1'b1, 10'd26, 8'd4}) begin
      n_bad++; $display("FAIL gaps_second got %0b/%0d/%0d want 1/26/4", a_valid, a_dout, a_cnt);
    end
    if (strobes !== 2) begin
      n_bad++; $display("FAIL gaps_strobes got %0d want 2", strobes);
    end
    step(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_flush();
    // v, d, f ; last flush is in IDLE with no sample
    logic [16:0] st[7] = '{{1'b1, 8'd5, 1'b0, 7'd0}, {1'b1, 8'd7, 1'b0, 7'd0},
                           {1'b0, 8'd0, 1'b1, 7'd0}, {1'b1, 8'd3, 1'b0, 7'd0},
                           {1'b1, 8'd9, 1'b1, 7'd0}, {1'b0, 8'd0, 1'b1, 7'd0},
                           {1'b0, 8'd0, 1'b0, 7'd0}};
    for (int i = 0; i < 7; i++) begin
      logic [16:0] e;
      e = st[i];
      step(e[16], e[15:8], e[7]);
      n_cmp += 2;
      if (a_valid !== e_valid) begin
        n_bad++; $display("FAIL flush_valid[%0d] got %0b want %0b", i, a_valid, e_valid);
      end
      if ({a_dout, a_cnt, a_ovf} !== {10'(e_a_dout), 8'(e_cnt), e_a_ovf}) begin
        n_bad++; $display("FAIL flush_out[%0d] got %0d/%0d/%0b want %0d/%0d/%0b", i, a_dout, a_cnt, a_ovf, e_a_dout, e_cnt, e_a_ovf);
      end
      if (i == 2 || i == 4) begin
        n_cmp += 1;
        if ({a_valid, a_dout, a_cnt} !== {1'b1, 10'd12, 8'd2}) begin
          n_bad++; $display("FAIL flush_fixed[%0d] got %0b/%0d/%0d want 1/12/2", i, a_valid, a_dout, a_cnt);
        end
      end
      if (i == 5) begin
        n_cmp += 1;
        if (a_valid !== 1'b0) begin
          n_bad++; $display("FAIL flush_idle got %0b want 0", a_valid);
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, 8'd255, 1'b0);
    n_cmp += 3;
    if ({a_valid, a_dout, a_cnt, a_ovf} !== {1'b1, 10'd1020, 8'd4, 1'b0}) begin
      n_bad++; $display("FAIL ovf_a got %0b/%0d/%0d/%0b want 1/1020/4/0", a_valid, a_dout, a_cnt, a_ovf);
    end
`ifdef STREAM_ACCUM_SAT_EN
    if ({b_valid, b_dout, b_cnt} !== {1'b1, 9'd511, 8'd4}) begin
      n_bad++; $display("FAIL ovf_b got %0b/%0d/%0d want 1/511/4", b_valid, b_dout, b_cnt);
    end
`else
    if ({b_valid, b_dout, b_cnt} !== {1'b1, 9'd508, 8'd4}) begin
      n_bad++; $display("FAIL ovf_b got %0b/%0d/%0d want 1/508/4", b_valid, b_dout, b_cnt);
    end
`endif
    if (b_ovf !== 1'b1) begin
      n_bad++; $display("FAIL ovf_b_flag got %0b want 1", b_ovf);
    end
    // Flag must clear on the next, non-overflowing group.
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
    n_cmp += 1;
    if ({b_valid, b_dout, b_ovf} !== {1'b1, 9'd4, 1'b0}) begin
      n_bad++; $display("FAIL ovf_clear got %0b/%0d/%0b want 1/4/0", b_valid, b_dout, b_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    step(1'b1, 8'd50, 1'b0);
    step(1'b1, 8'd60, 1'b0);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    n_cmp += 1;
    if ({a_valid, a_dout, a_cnt, a_ovf} !== 20'd0) begin
      n_bad++; $display("FAIL rstmid_async got %0b/%0d/%0d/%0b want 0/0/0/0", a_valid, a_dout, a_cnt, a_ovf);
    end
    @(posedge clk);
    #1;
    n_cmp += 1;
    if ({a_valid, a_dout, a_cnt, a_ovf} !== 20'd0) begin
      n_bad++; $display("FAIL rstmid_held got %0b/%0d/%0d/%0b want 0/0/0/0", a_valid, a_dout, a_cnt, a_ovf);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(i < 4, 8'd1, 1'b0);
      if (a_valid === 1'b1) strobes++;
      n_cmp += 2;
      if (a_valid !== e_valid) begin
        n_bad++; $display("FAIL rstmid_valid[%0d] got %0b want %0b", i, a_valid, e_valid);
      end
      if ({a_dout, a_cnt} !== {10'(e_a_dout), 8'(e_cnt)}) begin
        n_bad++; $display("FAIL rstmid_out[%0d] got %0d/%0d want %0d/%0d", i, a_dout, a_cnt, e_a_dout, e_cnt);
      end
    end
    n_cmp += 2;
    if (strobes !== 1) begin
      n_bad++; $display("FAIL rstmid_strobes got %0d want 1", strobes);
    end
    if ({a_dout, a_cnt} !== {10'd4, 8'd4}) begin
      n_bad++; $display("FAIL rstmid_fixed got %0d/%0d want 4/4", a_dout, a_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic v, f;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0);
      step(v, 8'($urandom), f);
      n_cmp += 4;
      if (a_valid !== e_valid) begin
        n_bad++; $display("FAIL rand_a_valid[%0d] got %0b want %0b", i, a_valid, e_valid);
      end
      if ({a_dout, a_cnt, a_ovf} !== {10'(e_a_dout), 8'(e_cnt), e_a_ovf}) begin
        n_bad++; $display("FAIL rand_a_out[%0d] got %0d/%0d/%0b want %0d/%0d/%0b", i, a_dout, a_cnt, a_ovf, e_a_dout, e_cnt, e_a_ovf);
      end
      if (b_valid !== e_valid) begin
        n_bad++; $display("FAIL rand_b_valid[%0d] got %0b want %0b", i, b_valid, e_valid);
      end
      if ({b_dout, b_cnt, b_ovf} !== {9'(e_b_dout), 8'(e_cnt), e_b_ovf}) begin
        n_bad++; $display("FAIL rand_b_out[%0d] got %0d/%0d/%0b want %0d/%0d/%0b", i, b_dout, b_cnt, b_ovf, e_b_dout, e_cnt, e_b_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps_back_to_back();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
